// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the sequenced CPU control block: opcodes, ALU codes,
// branch selects, FSM states and the opcode decode table.
package cpu_ctrl_pkg;

    localparam int unsigned OpLoadi = 0;
    localparam int unsigned OpMov   = 1;
    localparam int unsigned OpAdd   = 2;
    localparam int unsigned OpSub   = 3;
    localparam int unsigned OpAnd   = 4;
    localparam int unsigned OpOr    = 5;
    localparam int unsigned OpJ     = 6;
    localparam int unsigned OpBeq   = 7;
    localparam int unsigned OpBne   = 8;
    localparam int unsigned OpMult  = 9;
    localparam int unsigned OpSll   = 10;
    localparam int unsigned OpSrl   = 11;
    localparam int unsigned OpSra   = 12;
    localparam int unsigned OpRor   = 13;
    localparam int unsigned OpLwd   = 14;
    localparam int unsigned OpLwi   = 15;
    localparam int unsigned OpSwd   = 16;
    localparam int unsigned OpSwi   = 17;

    localparam logic [3:0] AluFwd  = 4'd0;
    localparam logic [3:0] AluAdd  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluMult = 4'd4;
    localparam logic [3:0] AluSll1 = 4'd5;
    localparam logic [3:0] AluSrl1 = 4'd6;
    localparam logic [3:0] AluSra1 = 4'd7;
    localparam logic [3:0] AluRor1 = 4'd8;

    localparam logic [1:0] BselNone = 2'b00;
    localparam logic [1:0] BselJump = 2'b01;
    localparam logic [1:0] BselBeq  = 2'b10;
    localparam logic [1:0] BselBne  = 2'b11;

    typedef enum logic [1:0] {StIdle, StExec, StIter, StMem} state_t;

    typedef struct packed {
        logic [3:0] aluop;
        logic       mux1op;
        logic       mux2op;
        logic [1:0] bselect;
        logic       wr;
        logic       known;
        logic       is_iter;
        logic       is_shift;
        logic       is_mem;
        logic       is_load;
    } dec_t;

    function automatic dec_t decode(input int unsigned op);
        dec_t d;
        d = '0;
        d.bselect = BselNone;
        d.known = 1'b1;
        case (op)
            OpLoadi: begin d.aluop = AluFwd; d.mux2op = 1'b1; d.wr = 1'b1; end
            OpMov:   begin d.aluop = AluFwd; d.wr = 1'b1; end
            OpAdd:   begin d.aluop = AluAdd; d.wr = 1'b1; end
            OpSub:   begin d.aluop = AluAdd; d.mux1op = 1'b1; d.wr = 1'b1; end
            OpAnd:   begin d.aluop = AluAnd; d.wr = 1'b1; end
            OpOr:    begin d.aluop = AluOr;  d.wr = 1'b1; end
            OpJ:     begin d.aluop = AluFwd; d.bselect = BselJump; end
            OpBeq:   begin d.aluop = AluAdd; d.mux1op = 1'b1; d.bselect = BselBeq; end
            OpBne:   begin d.aluop = AluAdd; d.mux1op = 1'b1; d.bselect = BselBne; end
            OpMult:  begin d.aluop = AluMult; d.wr = 1'b1; d.is_iter = 1'b1; end
            OpSll:   begin d.aluop = AluSll1; d.wr = 1'b1; d.is_shift = 1'b1; end
            OpSrl:   begin d.aluop = AluSrl1; d.wr = 1'b1; d.is_shift = 1'b1; end
            OpSra:   begin d.aluop = AluSra1; d.wr = 1'b1; d.is_shift = 1'b1; end
            OpRor:   begin d.aluop = AluRor1; d.wr = 1'b1; d.is_shift = 1'b1; end
            OpLwd: begin
                d.aluop = AluAdd; d.wr = 1'b1; d.is_mem = 1'b1; d.is_load = 1'b1;
            end
            OpLwi: begin
                d.aluop = AluAdd; d.mux2op = 1'b1; d.wr = 1'b1;
                d.is_mem = 1'b1; d.is_load = 1'b1;
            end
            OpSwd:   begin d.aluop = AluAdd; d.is_mem = 1'b1; end
            OpSwi:   begin d.aluop = AluAdd; d.mux2op = 1'b1; d.is_mem = 1'b1; end
            default: d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction-side and datapath-control bundle of the control FSM.
interface control_fsm_if #(
    parameter int unsigned OPCODE_W = 8,
    parameter int unsigned ALUOP_W  = 4,
    parameter int unsigned CNT_W    = 8
);
    logic                instr_valid;
    logic [OPCODE_W-1:0] opcode;
    logic [CNT_W-1:0]    imm_count;
    logic                busywait;
    logic                writeable;
    logic [ALUOP_W-1:0]  aluop;
    logic                mux1op;
    logic                mux2op;
    logic [1:0]          bselect;
    logic                alu_step;
    logic                mem_read;
    logic                mem_write;
    logic                pc_stall;
    logic                done;
    logic                illegal;

    modport master (
        output instr_valid, opcode, imm_count, busywait,
        input  writeable, aluop, mux1op, mux2op, bselect, alu_step,
        input  mem_read, mem_write, pc_stall, done, illegal
    );

    modport slave (
        input  instr_valid, opcode, imm_count, busywait,
        output writeable, aluop, mux1op, mux2op, bselect, alu_step,
        output mem_read, mem_write, pc_stall, done, illegal
    );
endinterface

// File: rtl/iter_counter.sv
// Loadable down-counter for multi-cycle ALU ops; last flags the final step.
module iter_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign count = count_q;
    assign last  = (count_q == CNT_W'(1));
endmodule

// File: rtl/control_fsm.sv
// Sequenced opcode decoder: single-cycle ops, iterative mult/shift and
// memory ops with busywait. All outputs are registered.
module control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 8,
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SHIFT_MAX   = 8,
    parameter int unsigned MULT_CYCLES = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    control_fsm_if.slave  bus
);
    state_t              state_q;
    logic [OPCODE_W-1:0] op_q;
    logic [ALUOP_W-1:0]  aluop_q;
    logic                writeable_q, mux1op_q, mux2op_q, alu_step_q;
    logic                mem_read_q, mem_write_q, pc_stall_q, done_q, illegal_q;
    logic [1:0]          bselect_q;

    logic [OPCODE_W-1:0] sel_op;
    dec_t                dec;
    logic [CNT_W-1:0]    cnt_clamp;
    logic [CNT_W-1:0]    load_val;
    logic [CNT_W-1:0]    count;
    logic                last;
    logic                go_iter;
    logic                cnt_load;

    // New opcode is decoded on acceptance; the latched one on MEM exit.
    assign sel_op    = (state_q == StIdle) ? bus.opcode : op_q;
    assign dec       = decode(32'(sel_op));
    assign cnt_clamp = (bus.imm_count > CNT_W'(SHIFT_MAX)) ? CNT_W'(SHIFT_MAX) : bus.imm_count;
    assign go_iter   = dec.is_iter || (dec.is_shift && cnt_clamp != '0);
    assign load_val  = dec.is_iter ? CNT_W'(MULT_CYCLES) : cnt_clamp;
    assign cnt_load  = (state_q == StIdle) && bus.instr_valid && go_iter;

    iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk      (CLK),
        .reset    (RESET),
        .load     (cnt_load),
        .load_val (load_val),
        .dec      (state_q == StIter),
        .count    (count),
        .last     (last)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            op_q        <= '0;
            aluop_q     <= '0;
            writeable_q <= 1'b0;
            mux1op_q    <= 1'b0;
            mux2op_q    <= 1'b0;
            bselect_q   <= 2'b00;
            alu_step_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            pc_stall_q  <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            aluop_q     <= '0;
            writeable_q <= 1'b0;
            mux1op_q    <= 1'b0;
            mux2op_q    <= 1'b0;
            bselect_q   <= 2'b00;
            alu_step_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            pc_stall_q  <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.instr_valid) begin
                        op_q <= bus.opcode;
                        if (dec.is_mem) begin
                            state_q     <= StMem;
                            aluop_q     <= ALUOP_W'(dec.aluop);
                            mux2op_q    <= dec.mux2op;
                            pc_stall_q  <= 1'b1;
                            mem_read_q  <= dec.is_load;
                            mem_write_q <= !dec.is_load;
                        end else if (go_iter) begin
                            state_q     <= StIter;
                            aluop_q     <= ALUOP_W'(dec.aluop);
                            alu_step_q  <= 1'b1;
                            pc_stall_q  <= 1'b1;
                            writeable_q <= (load_val == CNT_W'(1));
                            done_q      <= (load_val == CNT_W'(1));
                        end else begin
                            state_q     <= StExec;
                            aluop_q     <= dec.is_shift ? ALUOP_W'(AluFwd) : ALUOP_W'(dec.aluop);
                            mux1op_q    <= dec.mux1op;
                            mux2op_q    <= dec.mux2op;
                            bselect_q   <= dec.bselect;
                            writeable_q <= dec.wr;
                            done_q      <= 1'b1;
                            illegal_q   <= !dec.known;
                        end
                    end
                end
                StExec: state_q <= StIdle;
                StIter: begin
                    if (last) begin
                        state_q <= StIdle;
                    end else begin
                        // Counter steps down this edge, so 2 now means the final step next.
                        aluop_q     <= aluop_q;
                        alu_step_q  <= 1'b1;
                        pc_stall_q  <= 1'b1;
                        writeable_q <= (count == CNT_W'(2));
                        done_q      <= (count == CNT_W'(2));
                    end
                end
                StMem: begin
                    aluop_q  <= aluop_q;
                    mux2op_q <= mux2op_q;
                    if (bus.busywait) begin
                        pc_stall_q  <= 1'b1;
                        mem_read_q  <= mem_read_q;
                        mem_write_q <= mem_write_q;
                    end else begin
                        state_q     <= StExec;
                        writeable_q <= dec.wr;
                        done_q      <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.writeable = writeable_q;
    assign bus.aluop     = aluop_q;
    assign bus.mux1op    = mux1op_q;
    assign bus.mux2op    = mux2op_q;
    assign bus.bselect   = bselect_q;
    assign bus.alu_step  = alu_step_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.pc_stall  = pc_stall_q;
    assign bus.done      = done_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: each issued instruction queues its
// per-cycle expected output vector, popped and compared on every negedge.
module tb_control_fsm;
    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    control_fsm_if #(.OPCODE_W(8), .ALUOP_W(4), .CNT_W(8)) bus ();

    control_fsm #(
        .OPCODE_W    (8),
        .ALUOP_W     (4),
        .CNT_W       (8),
        .SHIFT_MAX   (8),
        .MULT_CYCLES (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // {writeable, aluop, mux1op, mux2op, bselect, alu_step, mem_read, mem_write, pc_stall, done, illegal}
    logic [14:0] obs;
    assign obs = {bus.writeable, bus.aluop, bus.mux1op, bus.mux2op, bus.bselect, bus.alu_step,
                  bus.mem_read, bus.mem_write, bus.pc_stall, bus.done, bus.illegal};

    logic [14:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] mk(input bit w, input int a, input bit m1, input bit m2,
                                       input int b, input bit st, input bit mr, input bit mw,
                                       input bit ps, input bit d, input bit il);
        return {w, 4'(a), m1, m2, 2'(b), st, mr, mw, ps, d, il};
    endfunction

    // Expected EXEC-cycle vector for single-cycle opcodes (incl. count-0 shifts).
    function automatic logic [14:0] exec_vec(input int op);
        case (op)
            0:  return mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
            1:  return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            2:  return mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            3:  return mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
            4:  return mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            5:  return mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            6:  return mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
            7:  return mk(0, 1, 1, 0, 2, 0, 0, 0, 0, 1, 0);
            8:  return mk(0, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0);
            10, 11, 12, 13: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            default: return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        endcase
    endfunction

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
        end
    end

    // Called at #1 after a posedge with the DUT idle. poke: cycle offset at which a
    // stray instr_valid is raised; abort: cycle offset during which RESET is held.
    task automatic run_instr(input int op, input int cnt, input int busy,
                             input int poke, input int abort);
        logic [14:0] seq[$];
        int          n;
        int          steps;
        bit          load;
        bit          m2;
        if (op >= 14 && op <= 17) begin
            load = (op == 14 || op == 15);
            m2   = (op == 15 || op == 17);
            for (int k = 1; k <= busy + 1; k++) seq.push_back(mk(0, 1, 0, m2, 0, 0, load, !load, 1, 0, 0));
            seq.push_back(mk(load, 1, 0, m2, 0, 0, 0, 0, 0, 1, 0));
        end else if (op == 9 || (op >= 10 && op <= 13 && cnt > 0)) begin
            n = (op == 9) ? 4 : ((cnt > 8) ? 8 : cnt);
            for (int k = 1; k <= n; k++) begin
                seq.push_back(mk(k == n, (op == 9) ? 4 : op - 5, 0, 0, 0, 1, 0, 0, 1, k == n, 0));
            end
        end else begin
            seq.push_back(exec_vec(op));
        end

        exp_q.push_back('0);
        tag_q.push_back($sformatf("op%0d idle", op));
        if (abort > 0) begin
            for (int k = 0; k < abort; k++) begin
                exp_q.push_back(seq[k]);
                tag_q.push_back($sformatf("op%0d cyc%0d", op, k + 1));
            end
            exp_q.push_back('0);
            tag_q.push_back($sformatf("op%0d after_reset", op));
            steps = abort + 1;
        end else begin
            for (int k = 0; k < seq.size(); k++) begin
                exp_q.push_back(seq[k]);
                tag_q.push_back($sformatf("op%0d cyc%0d", op, k + 1));
            end
            steps = seq.size();
        end

        bus.instr_valid = 1'b1;
        bus.opcode      = 8'(op);
        bus.imm_count   = 8'(cnt);
        bus.busywait    = 1'b0;
        for (int k = 1; k <= steps + 1; k++) begin
            @(posedge CLK);
            #1;
            bus.instr_valid = (k == poke);
            if (k == poke) bus.opcode = 8'd2;
            RESET        = (abort > 0 && k == abort);
            bus.busywait = (k <= busy);
        end
    endtask

    initial begin
        RESET           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.imm_count   = '0;
        bus.busywait    = 1'b0;
        @(posedge CLK);
        #1;
        exp_q.push_back('0);
        tag_q.push_back("reset");
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        for (int op = 0; op <= 8; op++) run_instr(op, 0, 0, 0, 0);
        run_instr(10, 3, 0, 0, 0);      // sll by 3
        run_instr(12, 200, 0, 0, 0);    // sra clamped to 8
        run_instr(9, 0, 0, 2, 0);       // mult, stray instr_valid mid-iteration
        run_instr(11, 0, 0, 0, 0);      // srl by 0 -> FWD in EXEC
        run_instr(13, 1, 0, 0, 0);      // ror by 1
        run_instr(14, 0, 2, 0, 0);      // lwd, 2 busy cycles
        run_instr(16, 0, 2, 0, 0);      // swd, 2 busy cycles
        run_instr(15, 0, 0, 0, 0);      // lwi, no wait
        run_instr(17, 0, 1, 0, 0);      // swi, 1 busy cycle
        run_instr(255, 0, 0, 0, 0);     // illegal
        run_instr(13, 8, 0, 0, 2);      // ror aborted by reset in 2nd iteration
        run_instr(2, 0, 0, 0, 0);       // add accepted after the abort
        for (int i = 0; i < 8; i++) begin
            run_instr(int'($urandom_range(0, 20)), int'($urandom_range(0, 12)),
                      int'($urandom_range(0, 3)), 0, 0);
        end

        repeat (2) @(negedge CLK);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
